// File: rtl/counter_dn7.sv
// counter_dn7: 3-bit down counter with reload, MARK/zero decodes and a done pulse on arrival at 0.
// Define COUNTER_DN_WRAP_EN to reload START after 0 instead of saturating.
module counter_dn7 #(
   parameter logic [2:0] START = 3'd7,
   parameter logic [2:0] MARK  = 3'd3
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       load,
   input  logic       en,
   output logic [2:0] count,
   output logic       out,
   output logic       zero,
   output logic       done
);
   logic [2:0] count_nx;
   logic       done_nx;
`ifdef COUNTER_DN_WRAP_EN
   localparam logic [2:0] AT_ZERO = START;
`else
   localparam logic [2:0] AT_ZERO = 3'd0;
`endif
   always_comb begin
      count_nx = load ? START : !en ? count : (count != 3'd0) ? count - 3'd1 : AT_ZERO;
      done_nx  = !load && en && (count == 3'd1);
   end
   always_ff @(posedge clk or negedge clear_n)
      if (!clear_n) begin
         count <= START;
         done  <= 1'b0;
      end else begin
         count <= count_nx;
         done  <= done_nx;
      end
   assign out  = (count == MARK);
   assign zero = (count == 3'd0);
endmodule
